// File: rtl/keypad_pkg.sv
// Shared keypad widths, FSM encoding and event packing helpers.
// Event format: [EVT_PRESS_BIT]=press(1)/release(0), [3:0]=key index.
package keypad_pkg;

  localparam int KEY_NUM       = 16;
  localparam int KEY_IDX_W     = 4;
  localparam int EVT_W         = 5;
  localparam int EVT_PRESS_BIT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_t;

  // Snapshot taken on acceptance; WALK consumes it one key per cycle.
  typedef struct packed {
    logic [KEY_NUM-1:0] diff;
    logic [KEY_NUM-1:0] nxt;
  } walk_ctx_t;

  function automatic logic [EVT_W-1:0] mk_evt(input logic press,
                                              input logic [KEY_IDX_W-1:0] idx);
    logic [EVT_W-1:0] e;
    e                = '0;
    e[EVT_PRESS_BIT] = press;
    e[KEY_IDX_W-1:0] = idx;
    return e;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO: write in cycle N is visible on out_* in N+1; head holds while !out_rdy.
// When empty, out_dat keeps the last popped word; a push on a full FIFO succeeds only with a same-cycle pop.
module evt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] last_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign out_vld = !empty;
  assign pop     = out_vld && out_rdy;
  assign in_rdy  = !full || out_rdy;
  assign push    = in_vld && in_rdy;
  assign out_dat = empty ? last_q : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Debounces the active-low keypad vector and emits per-key press/release events in ascending key order.
// Events reach evt_valid one cycle after the WALK step that finds them; a full queue drops events and sets overflow.
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int SAMPLE_DIV   = 50000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_raw,
  output logic               evt_valid,
  output logic [EVT_W-1:0]   evt_data,
  input  logic               evt_ready,
  output logic [KEY_NUM-1:0] key_state,
  output logic               overflow,
  input  logic               ovf_clr
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CNT);

  logic [KEY_NUM-1:0]   sync1_q;
  logic [KEY_NUM-1:0]   sync2_q;
  logic [KEY_NUM-1:0]   pressed;
  logic [DIV_W-1:0]     div_cnt_q;
  logic                 tick;
  logic [KEY_NUM-1:0]   hist_n_q;
  logic [KEY_NUM-1:0]   prev_sample;
  logic [STAB_W-1:0]    stab_cnt_q;
  logic                 accept;
  walk_state_t          state_q;
  walk_state_t          state_d;
  logic [KEY_IDX_W-1:0] idx_q;
  walk_ctx_t            ctx_q;
  logic [KEY_NUM-1:0]   key_state_q;
  logic                 ovf_q;
  logic                 push_vld;
  logic [EVT_W-1:0]     push_dat;
  logic                 push_rdy;

  assign pressed     = ~sync2_q;
  assign tick        = (div_cnt_q == DIV_LAST);
  // History is kept in the scanner's active-low form so reset reads as all released.
  assign prev_sample = ~hist_n_q;
  assign accept      = (stab_cnt_q == STAB_MAX) && (prev_sample != key_state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      div_cnt_q  <= '0;
      hist_n_q   <= '1;
      stab_cnt_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        if (pressed == prev_sample) begin
          if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_q <= stab_cnt_q + 1'b1;
          end
        end else begin
          stab_cnt_q <= STAB_W'(1);
          hist_n_q   <= sync2_q;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    push_vld = 1'b0;
    push_dat = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        push_vld = ctx_q.diff[idx_q];
        push_dat = mk_evt(ctx_q.nxt[idx_q], idx_q);
        if (idx_q == KEY_IDX_W'(KEY_NUM - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ctx_q       <= '0;
      key_state_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        idx_q <= '0;
        if (accept) begin
          ctx_q.diff <= prev_sample ^ key_state_q;
          ctx_q.nxt  <= prev_sample;
        end
      end else begin
        idx_q <= idx_q + 1'b1;
        if (ctx_q.diff[idx_q]) begin
          key_state_q[idx_q] <= ctx_q.nxt[idx_q];
        end
      end
    end
  end

  // A dropped push outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push_vld),
    .in_dat  (push_dat),
    .in_rdy  (push_rdy),
    .out_vld (evt_valid),
    .out_dat (evt_data),
    .out_rdy (evt_ready)
  );

  assign key_state = key_state_q;
  assign overflow  = ovf_q;

endmodule
